serial_divider: RTL and testbench
=================================

SERIAL_DIVIDER -- requirements
Module: serial_divider

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-004 Port start, input, 1, SHALL request a new operation (level, sampled on the clock edge).
REQ-005 Port op, input, 2, SHALL select the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 Ports dividend and divisor, input, XLEN each, SHALL be the operands, sampled only when start is accepted.
REQ-007 Port busy, output, 1, SHALL be high while an operation is in progress.
REQ-008 Port done, output, 1, SHALL be a one-cycle pulse marking result valid.
REQ-009 Port result, output, XLEN, SHALL carry the quotient or remainder.

Function
REQ-010 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
- busy SHALL be 1 in CALC and FIX only.
- done SHALL be 1 in DONE only.
REQ-011 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE.
- On acceptance the block SHALL latch op and both operands.
- It SHALL then go to CALC with the iteration counter at 0.
REQ-012 start while busy=1 SHALL be ignored; latched operands and progress SHALL be unaffected.
REQ-013 CALC SHALL perform one restoring shift-subtract iteration per cycle on magnitudes.
- This stage covers exactly XLEN cycles.
- The FSM SHALL then go to FIX.
REQ-014 Magnitudes SHALL be handled as follows:
- Signed ops (DIV, REM) SHALL use the two's-complement absolute value of each operand.
- Unsigned ops SHALL use the operands as-is.
REQ-015 FIX SHALL apply sign correction and the special cases, register result, and go to DONE.
- Quotient sign SHALL be sign(dividend) XOR sign(divisor).
- Remainder sign SHALL be sign(dividend).
REQ-016 Divide by zero SHALL give:
- DIV and DIVU: result all ones.
- REM and REMU: result = dividend.
- Latency unchanged.
REQ-017 Signed overflow (dividend = -2^(XLEN-1), divisor = -1) SHALL give:
- DIV: result = -2^(XLEN-1).
- REM: result = 0.
REQ-018 Latency SHALL be fixed at XLEN+2 cycles.
- Measured from the edge that accepts start to the first cycle with done=1 (34 for XLEN=32).
- This holds for every operand value.
REQ-019 DONE SHALL last one cycle.
- Without start it SHALL return to IDLE.
- With start (back-to-back) it SHALL go directly to CALC.
REQ-020 result SHALL hold its value from DONE until the next FIX.

Reset
REQ-021 With rst_n=0 at a clock edge, the block SHALL, regardless of state (including mid-CALC):
- enter IDLE;
- drive busy=0, done=0 and result=0;
- clear the counter and internal registers.
REQ-022 An operation interrupted by reset SHALL be discarded; no done pulse SHALL follow.
REQ-023 start sampled during reset SHALL be ignored.

Structure
REQ-024 A shared package SHALL hold:
- the op encodings (DIV, DIVU, REM, REMU);
- the FSM state encoding;
- the default XLEN.
REQ-025 A combinational sub-module div_step SHALL implement one iteration.
- Inputs: partial remainder and quotient registers, divisor magnitude.
- Outputs: next partial remainder and quotient.
- The top level SHALL hold the FSM, counter and registers.
REQ-026 Operand and sign handling SHALL use the team's existing adder style; no library divider SHALL be used.

Verification
REQ-027 DIVU 100/7 -> done at cycle 34, result 14; REMU 100/7 -> result 2.
REQ-028 DIV -100/7 -> result -14 (0xFFFFFFF2); REM -100/7 -> result -2 (0xFFFFFFFE).
REQ-029 Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
REQ-030 Overflow cases:
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM with the same operands -> 0.
REQ-031 Busy and back-to-back handling:
- start pulses during busy -> ignored, the first result is unchanged.
- start in the DONE cycle -> second done exactly 34 cycles later.
REQ-032 rst_n=0 at cycle 10 of CALC -> next cycle busy=0, done=0, result=0; no done pulse follows.

Source files
------------

// File: rtl/serial_divider_pkg.sv
// Shared definitions for the serial divider: op encodings, FSM states, default width.
package serial_divider_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/serial_divider_div_step.sv
// One restoring shift-subtract iteration on magnitudes (purely combinational).
module div_step
  import serial_divider_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  // The shifted partial remainder can reach XLEN+1 bits, so subtract at that width.
  assign w_sh   = {i_rem, i_quo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, i_dvs};
  assign w_ge   = ~w_diff[XLEN];

  assign o_rem = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/serial_divider.sv
// Fixed-latency restoring divider: XLEN CALC cycles, one FIX cycle, one-cycle DONE pulse.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          r_state;
  state_e          w_next;
  op_e             r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_result;
  logic            r_dvd_neg;
  logic            r_dvs_neg;

  op_e             w_op_in;
  logic            w_accept;
  logic            w_signed_in;
  logic            w_dvd_neg_in;
  logic            w_dvs_neg_in;
  logic [XLEN-1:0] w_dvd_abs;
  logic [XLEN-1:0] w_dvs_abs;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic            w_is_rem;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_q_signed;
  logic [XLEN-1:0] w_r_signed;
  logic [XLEN-1:0] w_fix_result;

  assign w_op_in      = op_e'(op);
  assign w_accept     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_signed_in  = (w_op_in == OP_DIV) || (w_op_in == OP_REM);
  assign w_dvd_neg_in = w_signed_in & dividend[XLEN-1];
  assign w_dvs_neg_in = w_signed_in & divisor[XLEN-1];
  // -2^(XLEN-1) negates to itself, which is the correct unsigned magnitude.
  assign w_dvd_abs    = w_dvd_neg_in ? (~dividend + XLEN'(1)) : dividend;
  assign w_dvs_abs    = w_dvs_neg_in ? (~divisor + XLEN'(1)) : divisor;

  div_step #(.XLEN(XLEN)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: if (r_cnt == CW'(XLEN-1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = w_accept ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CALC) || (r_state == S_FIX);
    done = (r_state == S_DONE);
  end

  // Sign fix-up and special cases; the neg flags are only ever set for signed ops.
  assign w_is_rem   = (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_div_zero = (r_dvs == '0);
  assign w_overflow = r_dvd_neg && (r_dvd == MIN_NEG) && r_dvs_neg && (r_dvs == XLEN'(1));
  assign w_q_signed = (r_dvd_neg ^ r_dvs_neg) ? (~r_quo + XLEN'(1)) : r_quo;
  assign w_r_signed = r_dvd_neg ? (~r_rem + XLEN'(1)) : r_rem;

  always_comb begin
    w_fix_result = w_is_rem ? w_r_signed : w_q_signed;
    if (w_div_zero)      w_fix_result = w_is_rem ? r_dvd : '1;
    else if (w_overflow) w_fix_result = w_is_rem ? '0 : MIN_NEG;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= OP_DIV;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_op      <= w_op_in;
        r_dvd     <= dividend;
        r_dvs     <= w_dvs_abs;
        r_rem     <= '0;
        r_quo     <= w_dvd_abs;
        r_dvd_neg <= w_dvd_neg_in;
        r_dvs_neg <= w_dvs_neg_in;
        r_cnt     <= '0;
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_FIX) r_result <= w_fix_result;
    end
  end

  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider: latency, signed/unsigned results, special cases, busy/reset behaviour.
module tb_serial_divider;
  import serial_divider_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  serial_divider #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start for exactly one rising edge, returns in cycle 1 after acceptance.
  task automatic launch(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat0);
    int lat;
    logic [XLEN-1:0] e;
    lat = lat0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, XLEN'(lat), XLEN'(LAT));
    e = exp_q.pop_front();
    check({tag, " result"}, result, e);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    @(negedge clk);
    launch(o, a, b, exp);
    wait_done(tag, 1);
  endtask

  initial begin
    int ndone;

    // Reset state, with start held high to confirm it is ignored during reset
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", XLEN'(busy), '0);
    check("reset done", XLEN'(done), '0);
    check("reset result", result, '0);
    check("reset state", XLEN'(dbg_state), XLEN'(S_IDLE));
    start = 1'b0;
    rst_n = 1'b1;

    // Unsigned and signed basics
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 32'd2);
    run_op("div -100/7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    run_op("rem -100/7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    run_op("div 100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_op("rem 100/-7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2);
    run_op("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14);
    run_op("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);

    // Result holds after DONE while idle
    repeat (3) @(negedge clk);
    check("hold result", result, 32'h0FFF_FFFF);
    check("hold done", XLEN'(done), '0);
    check("hold state", XLEN'(dbg_state), XLEN'(S_IDLE));

    // Divide by zero
    run_op("divu x/0", OP_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    run_op("rem x/0", OP_REM, 32'h0000_1234, 32'd0, 32'h0000_1234);
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_op("remu x/0", OP_REMU, 32'h8000_0001, 32'd0, 32'h8000_0001);

    // Signed overflow
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // start while busy is ignored
    @(negedge clk);
    launch(OP_DIVU, 32'd100, 32'd7, 32'd14);
    check("busy in calc", XLEN'(busy), XLEN'(1));
    repeat (2) @(negedge clk);
    op = OP_DIV; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("busy ignore", 6);

    // Back-to-back: start in the DONE cycle
    @(negedge clk);
    launch(OP_DIVU, 32'd100, 32'd7, 32'd14);
    wait_done("b2b first", 1);
    launch(OP_REMU, 32'd50, 32'd8, 32'd2);
    wait_done("b2b second", 1);

    // Reset at cycle 10 of CALC discards the operation
    @(negedge clk);
    launch(OP_DIVU, 32'd100, 32'd7, 32'd14);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("midreset busy", XLEN'(busy), '0);
    check("midreset done", XLEN'(done), '0);
    check("midreset result", result, '0);
    rst_n = 1'b1;
    start = 1'b0;
    exp_q.delete();
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after reset", XLEN'(ndone), '0);
    check("idle after reset", XLEN'(dbg_state), XLEN'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
